// File: rtl/cover_toggle_collector.sv
// ============================================================================
// Module   : cover_toggle_collector
// Purpose  : On-chip toggle cover collector: sticky hit bitmap, saturating
//            per-point hit counters and a valid/ready stream of first hits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cover_toggle_collector #(
    parameter int WIDTH       = 39,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 10906,
    parameter int CNT_W       = 8,
    parameter int SEL_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             valid,
    input  logic                         enable,
    input  logic                         clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_index,
    input  logic [SEL_W-1:0]             rd_sel,
    output logic [CNT_W-1:0]             rd_count,
    output logic [$clog2(WIDTH+1)-1:0]   covered_count,
    output logic                         all_covered
);

    localparam int               c_cov_w   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [0:0]       c_idle    = 1'b0;
    localparam logic [0:0]       c_present = 1'b1;

    generate
        if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
            $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
        end
        if (WIDTH < 1 || WIDTH > 1024 || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
            $error("cover_toggle_collector: WIDTH or CNT_W out of range");
        end
    endgenerate

    logic [WIDTH-1:0]   r_hit;
    logic [WIDTH-1:0]   r_pending;
    logic [CNT_W-1:0]   r_cnt [WIDTH];
    logic [0:0]         r_state;
    logic [63:0]        r_out_index;
    logic [CNT_W-1:0]   r_rd_count;
    logic [c_cov_w-1:0] r_covered;
    logic               r_all;

    logic [WIDTH-1:0]   w_acc;
    logic [WIDTH-1:0]   w_new;
    logic [WIDTH-1:0]   w_low_onehot;
    logic [63:0]        w_low_index;
    logic               w_any;
    logic               w_load;
    logic [CNT_W-1:0]   w_rd_mux;
    logic [c_cov_w-1:0] w_popcount;

    // Priority pick of the lowest pending point; only registered pending
    // bits take part, so hits landing this edge wait one cycle.
    always_comb begin
        w_acc        = valid & {WIDTH{enable}};
        w_new        = w_acc & ~r_hit;
        w_any        = |r_pending;
        w_low_onehot = '0;
        w_low_index  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_onehot    = '0;
                w_low_onehot[i] = 1'b1;
                w_low_index     = 64'(i);
            end
        end
        w_load = w_any && ((r_state == c_idle) || out_ready);
    end

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcount = w_popcount + c_cov_w'(r_hit[i]);
        end
        w_rd_mux = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(rd_sel) == i) begin
                w_rd_mux = r_cnt[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_hit       <= '0;
            r_pending   <= '0;
            r_state     <= c_idle;
            r_out_index <= '0;
            r_rd_count  <= '0;
            r_covered   <= '0;
            r_all       <= 1'b0;
        end else begin
            r_hit      <= r_hit | w_new;
            r_pending  <= (w_load ? (r_pending & ~w_low_onehot) : r_pending) | w_new;
            r_rd_count <= w_rd_mux;
            r_covered  <= w_popcount;
            r_all      <= (w_popcount == c_cov_w'(WIDTH));
            case (r_state)
                c_idle: begin
                    if (w_any) begin
                        r_state     <= c_present;
                        r_out_index <= 64'(COVER_INDEX) + w_low_index;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (w_any) begin
                            r_out_index <= 64'(COVER_INDEX) + w_low_index;
                        end else begin
                            r_state <= c_idle;
                        end
                    end
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
            always_ff @(posedge clock) begin
                if (reset || clear) begin
                    r_cnt[g] <= '0;
                end else if (w_acc[g] && (r_cnt[g] != c_cnt_max)) begin
                    r_cnt[g] <= r_cnt[g] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign out_valid     = (r_state == c_present);
    assign out_index     = r_out_index;
    assign rd_count      = r_rd_count;
    assign covered_count = r_covered;
    assign all_covered   = r_all;

endmodule

`default_nettype wire

// File: tb/tb_cover_toggle_collector.sv
// ============================================================================
// Module   : tb_cover_toggle_collector
// Purpose  : Directed scenarios plus randomized traffic for the toggle cover
//            collector, checked every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cover_toggle_collector;

    localparam int W     = 39;
    localparam int CI    = 100;
    localparam int CNT_W = 8;
    localparam int SEL_W = 6;
    localparam int CW    = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [W-1:0]     valid = '0;
    logic             enable = 1'b0;
    logic             clear = 1'b0;
    logic             out_ready = 1'b0;
    logic [SEL_W-1:0] rd_sel = '0;
    logic             out_valid;
    logic [63:0]      out_index;
    logic [CNT_W-1:0] rd_count;
    logic [CW-1:0]    covered_count;
    logic             all_covered;

    cover_toggle_collector #(
        .WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(10906), .CNT_W(CNT_W), .SEL_W(SEL_W)
    ) dut (
        .clock(clock), .reset(reset), .valid(valid), .enable(enable), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .rd_sel(rd_sel), .rd_count(rd_count), .covered_count(covered_count),
        .all_covered(all_covered)
    );

    always #5 clock = ~clock;

    int      total = 0;
    int      bad = 0;
    bit      chk_en = 1'b0;
    longint  beats[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a set of hit points, a set of waiting points, a
    // presented event and saturating hit tallies.
    bit     m_hit  [W];
    bit     m_pend [W];
    int     m_cnt  [W];
    bit     m_valid;
    longint m_index;
    int     e_cov, e_all, e_rd, pc;

    always @(posedge clock) begin
        if (reset || clear) begin
            for (int i = 0; i < W; i++) begin
                m_hit[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
            end
            m_valid = 0; m_index = 0; e_cov = 0; e_all = 0; e_rd = 0;
        end else begin
            pc = 0;
            for (int i = 0; i < W; i++) pc += int'(m_hit[i]);
            e_cov = pc;
            e_all = (pc == W) ? 1 : 0;
            e_rd  = (int'(rd_sel) < W) ? m_cnt[rd_sel] : 0;
            if (m_valid && out_ready) m_valid = 0;
            if (!m_valid) begin
                for (int i = 0; i < W; i++) begin
                    if (m_pend[i]) begin
                        m_valid = 1; m_index = CI + i; m_pend[i] = 0;
                        break;
                    end
                end
            end
            if (enable) begin
                for (int i = 0; i < W; i++) begin
                    if (valid[i]) begin
                        if (!m_hit[i]) begin m_hit[i] = 1; m_pend[i] = 1; end
                        if (m_cnt[i] < CMAX) m_cnt[i]++;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("out_valid", longint'(out_valid), longint'(m_valid));
            if (m_valid) chk("out_index", longint'(out_index), m_index);
            chk("covered_count", longint'(covered_count), longint'(e_cov));
            chk("all_covered", longint'(all_covered), longint'(e_all));
            chk("rd_count", longint'(rd_count), longint'(e_rd));
        end
        if (out_valid === 1'b1 && out_ready) beats.push_back(longint'(out_index));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0; beats.delete();
    endtask

    initial begin
        tick(3);
        chk_en = 1'b1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_index", longint'(out_index), 0);
        chk("rst_rd_count", longint'(rd_count), 0);
        chk("rst_covered", longint'(covered_count), 0);
        chk("rst_all", longint'(all_covered), 0);
        reset = 1'b0; enable = 1'b1; out_ready = 1'b1; beats.delete();

        // Single hit: latency two cycles, one beat.
        valid = W'(1); tick(); valid = '0;
        chk("lat_t1_valid", longint'(out_valid), 0);
        tick();
        chk("lat_t2_valid", longint'(out_valid), 1);
        chk("lat_t2_index", longint'(out_index), CI);
        tick(3);
        chk("t1_beats", beats.size(), 1);
        if (beats.size() == 1) chk("t1_beat0", beats[0], CI);
        chk("t1_covered", longint'(covered_count), 1);

        // Three hits in one cycle drain in ascending order.
        beats.delete();
        valid = '0; valid[5] = 1'b1; valid[2] = 1'b1; valid[38] = 1'b1;
        tick(); valid = '0; tick(6);
        chk("t2_beats", beats.size(), 3);
        if (beats.size() == 3) begin
            chk("t2_beat0", beats[0], CI + 2);
            chk("t2_beat1", beats[1], CI + 5);
            chk("t2_beat2", beats[2], CI + 38);
        end
        chk("t2_valid_low", longint'(out_valid), 0);
        chk("t2_all", longint'(all_covered), 0);

        // Backpressure: presented event holds, lower hit does not preempt.
        do_clear();
        out_ready = 1'b0;
        valid = '0; valid[7] = 1'b1; tick(); valid = '0;
        for (int i = 0; i < 5 && out_valid !== 1'b1; i++) tick();
        chk("t3_wait_valid", longint'(out_valid), 1);
        valid[3] = 1'b1; tick(); valid = '0; tick(9);
        chk("t3_held_index", longint'(out_index), CI + 7);
        out_ready = 1'b1; tick(4);
        chk("t3_beats", beats.size(), 2);
        if (beats.size() == 2) begin
            chk("t3_beat0", beats[0], CI + 7);
            chk("t3_beat1", beats[1], CI + 3);
        end

        // Counter saturation, single event for a repeatedly hit point.
        do_clear();
        rd_sel = SEL_W'(4);
        valid = '0; valid[4] = 1'b1; tick(300); valid = '0; tick(3);
        chk("t4_rd_sat", longint'(rd_count), CMAX);
        chk("t4_beats", beats.size(), 1);
        if (beats.size() == 1) chk("t4_beat0", beats[0], CI + 4);

        // Clear mid-drain with ready high.
        do_clear();
        valid = '1; tick(); valid = '0; tick(6);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t5_valid", longint'(out_valid), 0);
        chk("t5_covered", longint'(covered_count), 0);
        chk("t5_rd", longint'(rd_count), 0);
        beats.delete();
        valid = W'(1); tick(); valid = '0; tick(4);
        chk("t5_beats", beats.size(), 1);
        if (beats.size() == 1) chk("t5_beat0", beats[0], CI);

        // enable low blocks everything; then all points drain.
        do_clear();
        enable = 1'b0; valid = '1; tick(5);
        chk("t6_no_beats", beats.size(), 0);
        chk("t6_covered", longint'(covered_count), 0);
        chk("t6_rd", longint'(rd_count), 0);
        enable = 1'b1; tick(); valid = '0; tick(45);
        chk("t6_beats", beats.size(), W);
        if (beats.size() == W) begin
            for (int i = 0; i < W; i++) chk("t6_order", beats[i], CI + i);
        end
        chk("t6_all", longint'(all_covered), 1);

        // Randomized traffic under the model.
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < W; b++) valid[b] = ($urandom_range(15) == 0);
            enable    = ($urandom_range(7) != 0);
            out_ready = ($urandom_range(3) != 0);
            rd_sel    = SEL_W'($urandom_range(63));
            clear     = ($urandom_range(63) == 0);
            reset     = ($urandom_range(255) == 0);
            tick();
        end
        clear = 1'b0; reset = 1'b0; valid = '0; tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cover_toggle_collector.md
Name: cover_toggle_collector

Overview:
- Synthesizable, parametrised successor to the DPI-only toggle cover block.
- Records toggle cover points on-chip instead of calling a simulator function. Each point has a sticky hit bit and a saturating hit counter.
- Streams each point's first-hit global index over a valid/ready port, reports how many points are covered, and allows per-point counter readback.
- Sits beside the DUT's toggle-coverage instrumentation, one instance per cover group. It is usable in FPGA/emulation builds where DPI is unavailable.

Parameters:
- WIDTH, 39, number of cover points (valid bits) in this group, 1..1024.
- COVER_INDEX, 0, global index of point 0; point i reports COVER_INDEX+i.
- COVER_TOTAL, 10906, total design cover points; used only for the width sanity check COVER_INDEX+WIDTH <= COVER_TOTAL.
- CNT_W, 8, width of each per-point saturating hit counter, 1..32.
- SEL_W, max(1,$clog2(WIDTH)), width of the readback select.

Ports:
- clock  in  1  single clock, all logic posedge.
- reset  in  1  synchronous, active-high reset.
- valid  in  WIDTH  toggle events this cycle, bit i = point i hit.
- enable  in  1  when 0, valid is ignored (no bitmap/counter/event update).
- clear  in  1  synchronous clear of bitmap, pending, counters and output register.
- out_valid  out  1  first-hit event available.
- out_ready  in  1  consumer accepts event.
- out_index  out  64  global index of the presented event, zero-extended.
- rd_sel  in  SEL_W  counter readback select.
- rd_count  out  CNT_W  counter of point rd_sel, 1-cycle latency.
- covered_count  out  $clog2(WIDTH+1)  number of sticky hit bits set, registered.
- all_covered  out  1  covered_count == WIDTH, registered.

Behaviour:
- Reset: hit, pending and all counters are cleared. out_valid=0, out_index=0, rd_count=0, covered_count=0, all_covered=0. FSM goes to IDLE.
- Accepted hits: acc = valid & {WIDTH{enable}} when !reset && !clear.
- Bitmap update: new = acc & ~hit. On the next edge, hit |= new and pending |= new.
- A point enters pending exactly once per reset/clear epoch; repeated hits do not re-queue it.
- Counters: if acc[i], cnt[i] increments and saturates at 2^CNT_W-1; it never wraps.
- FSM IDLE:
  - If pending != 0, latch out_index = COVER_INDEX + (lowest set pending bit).
  - Clear that pending bit, set out_valid=1 and go to PRESENT.
  - Pending bits set in the same edge are not visible until the next cycle.
- FSM PRESENT:
  - out_valid=1. out_index must stay stable until out_ready.
  - On out_valid && out_ready: if pending != 0, load the next lowest index in the same edge (back-to-back, one event/cycle throughput) and stay in PRESENT.
  - Otherwise drop out_valid and go to IDLE.
  - A newly hit lower index does not preempt the event currently presented.
- Ordering: events leave in ascending index among the points pending at each load, not in global hit order.
- Latency: valid at cycle t gives out_valid at t+2 at the earliest, from IDLE with an empty queue.
- covered_count and all_covered reflect the hit bitmap with 1 cycle of lag, i.e. the popcount of the registered hit.
- rd_count = cnt[rd_sel] registered. rd_sel >= WIDTH returns 0.
- clear:
  - Same effect as reset on all state. It has priority over simultaneous valid and out_ready.
  - An event presented at clear is dropped; the handshake is not completed.
- reset or clear mid-transfer: out_valid drops the next cycle, even if out_ready was low.
- enable=0: pending events continue to drain, counters hold, and no new hits are accepted.
- WIDTH=1: SEL_W=1, and the single point drains normally.
- Elaboration error if COVER_INDEX+WIDTH > COVER_TOTAL.

Test Plan:
- Reset, then valid=39'h1 for 1 cycle with out_ready=1 -> out_valid at cycle +2, out_index=COVER_INDEX+0, one beat only. covered_count=1.
- valid bits 5, 2, 38 in one cycle, out_ready=1 -> three consecutive beats with indices +2, +5, +38, then out_valid=0. all_covered=0.
- Hold out_ready=0 for 10 cycles while the event for bit 7 is presented and bit 3 is hit meanwhile -> out_index stays +7. After ready, the next beat is +3.
- Pulse bit 4 300 times with CNT_W=8, rd_sel=4 -> rd_count=255 (saturated). Bit 4 emits exactly one event.
- Drive all bits, then assert clear together with out_ready mid-drain -> the next cycle shows out_valid=0, covered_count=0 and rd_count=0. Re-hitting bit 0 re-emits +0.
- enable=0 with valid=all ones for 5 cycles -> no events, counters and covered_count stay 0. Raise enable -> all 39 events drain, then all_covered=1.
